// File: rtl/param_sram_ctrl.sv
// Parametrised single-port synchronous SRAM with byte-lane write enables,
// a registered read port behind a valid/ready handshake, and a clear engine
// that sweeps every word to CLEAR_VAL after reset or on clear_start.
module param_sram_ctrl #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          DEPTH     = 16,
  parameter logic [DATA_W-1:0]    CLEAR_VAL = '0,
  localparam int unsigned         ADDR_W    = $clog2(DEPTH),
  localparam int unsigned         BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              clear_start,
  output logic              busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                in_range;
  logic                wr_en;
  logic                clr_en;
  logic [DATA_W-1:0]   cur_word;
  logic [DATA_W-1:0]   wr_word;

  // Status outputs decode straight from the state register.
  assign busy      = (state_q == ST_CLEAR);
  assign req_ready = (state_q == ST_READY);

  assign accept    = req_valid && req_ready;
  // Only reachable when DEPTH is not a power of two.
  assign in_range  = (32'(req_addr) < DEPTH);
  assign wr_en     = accept && req_we && in_range;
  assign clr_en    = (state_q == ST_CLEAR);

  // Current contents of the addressed word; zero for out-of-range reads.
  always_comb begin
    cur_word = '0;
    if (in_range) cur_word = mem_q[req_addr];
  end

  // Merge write data into the current word lane by lane.
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign wr_word[i*8 +: 8] = req_be[i] ? req_wdata[i*8 +: 8] : cur_word[i*8 +: 8];
  end

  // Storage: the clear sweep and request writes never overlap since they
  // live in different FSM states. Contents are not reset.
  always_ff @(posedge clk) begin
    if (clr_en)     mem_q[clr_cnt_q] <= CLEAR_VAL;
    else if (wr_en) mem_q[req_addr]  <= wr_word;
  end

  // Next-state: sweep sequencing, clear_start handling and read response.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // clear_start is ignored here; the sweep never restarts mid-way.
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (clear_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
    // A read accepted on the clear_start edge still returns pre-clear data,
    // because the array is sampled before the sweep's first write.
    if (accept && !req_we) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = cur_word;
      rsp_err_d   = !in_range;
    end
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_param_sram_ctrl.sv
// Bench for param_sram_ctrl: a default 16x32 instance (A) and a 12x16
// instance (B). Reads push expected responses into per-instance queues;
// negedge monitors pop and compare whenever rsp_valid is seen.
module tb_param_sram_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   a_pulses;
  int   b_pulses;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A: defaults, CLEAR_VAL = DEADBEEF
  logic        a_valid, a_ready, a_we, a_rsp_valid, a_rsp_err, a_clr, a_busy;
  logic [3:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0]  a_be;

  // Instance B: DEPTH=12, DATA_W=16, CLEAR_VAL = C1EA
  logic        b_valid, b_ready, b_we, b_rsp_valid, b_rsp_err, b_clr, b_busy;
  logic [3:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [1:0]  b_be;

  param_sram_ctrl #(.DATA_W(32), .DEPTH(16), .CLEAR_VAL(32'hDEADBEEF)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_be(a_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err),
    .clear_start(a_clr), .busy(a_busy)
  );

  param_sram_ctrl #(.DATA_W(16), .DEPTH(12), .CLEAR_VAL(16'hC1EA)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err),
    .clear_start(b_clr), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor A
  always @(negedge clk) begin
    if (a_rsp_valid === 1'b1) begin
      a_pulses++;
      if (qa.size() == 0) begin
        chk("A_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("A_rdata", a_rdata, e.data);
        chk("A_err", {31'd0, a_rsp_err}, {31'd0, e.err});
        chk("A_latency_cyc", cyc, e.cyc);
      end
    end else if (a_rsp_err !== 1'b0) begin
      chk("A_err_without_valid", {31'd0, a_rsp_err}, 32'd0);
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (b_rsp_valid === 1'b1) begin
      b_pulses++;
      if (qb.size() == 0) begin
        chk("B_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("B_rdata", {16'd0, b_rdata}, e.data);
        chk("B_err", {31'd0, b_rsp_err}, {31'd0, e.err});
        chk("B_latency_cyc", cyc, e.cyc);
      end
    end else if (b_rsp_err !== 1'b0) begin
      chk("B_err_without_valid", {31'd0, b_rsp_err}, 32'd0);
    end
  end

  // Offer one request, wait (bounded) for acceptance, push the expected
  // read response. Leaves req_valid high so callers can chain requests.
  task automatic issue(input bit b, input bit we, input logic [3:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input bit clr,
                       input logic [31:0] exp, input bit experr);
    int w;
    exp_t e;
    w = 0;
    if (!b) begin
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be; a_clr = clr;
    end else begin
      b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd[15:0]; b_be = be[1:0]; b_clr = clr;
    end
    while (!(b ? b_ready : a_ready) && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    a_clr = 1'b0;
    b_clr = 1'b0;
    if (!we) begin
      e.data = exp; e.err = experr; e.cyc = cyc;
      if (!b) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
  endtask

  // Count edges until A is ready, capturing B's ready edge on the way.
  task automatic wait_ready(output int na, output int nb);
    na = 0; nb = -1;
    while (!a_ready && na < 100) begin
      @(posedge clk); #1; na++;
      if (b_ready && nb < 0) nb = na;
    end
  endtask

  initial begin
    int na, nb, n, p0;
    cyc = 0; total = 0; bad = 0; a_pulses = 0; b_pulses = 0;
    rst_n = 1'b0;
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0; a_clr = 0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0; b_clr = 0;
    #2;
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd1);
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", {31'd0, a_rsp_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Clear latency after reset
    wait_ready(na, nb);
    chk("A_clear_edges", na, 32'd16);
    chk("B_clear_edges", nb, 32'd12);
    chk("A_busy_after_clear", {31'd0, a_busy}, 32'd0);

    // Cleared contents
    issue(0, 0, 4'd0,  '0, '0, 0, 32'hDEADBEEF, 0);
    issue(0, 0, 4'd7,  '0, '0, 0, 32'hDEADBEEF, 0);
    issue(0, 0, 4'd15, '0, '0, 0, 32'hDEADBEEF, 0);

    // Byte enables
    issue(0, 1, 4'd3, 32'h11223344, 4'hF,    0, '0, 0);
    issue(0, 1, 4'd3, 32'hAABBCCDD, 4'b0101, 0, '0, 0);
    issue(0, 0, 4'd3, '0, '0, 0, 32'h11BB33DD, 0);
    idle();
    @(posedge clk); #1;

    // Back-to-back traffic, read-after-write on consecutive edges
    p0 = a_pulses;
    chk("b2b_ready0", {31'd0, a_ready}, 32'd1);
    issue(0, 1, 4'd1, 32'hA5, 4'hF, 0, '0, 0);
    chk("b2b_ready1", {31'd0, a_ready}, 32'd1);
    issue(0, 1, 4'd2, 32'h5A, 4'hF, 0, '0, 0);
    chk("b2b_ready2", {31'd0, a_ready}, 32'd1);
    issue(0, 0, 4'd1, '0, '0, 0, 32'hA5, 0);
    chk("b2b_ready3", {31'd0, a_ready}, 32'd1);
    issue(0, 0, 4'd2, '0, '0, 0, 32'h5A, 0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_pulse_count", a_pulses - p0, 32'd2);

    // Clear collision: read of addr 2 accepted on the clear_start edge
    issue(0, 0, 4'd2, '0, '0, 1, 32'h5A, 0);
    idle();
    chk("collide_busy", {31'd0, a_busy}, 32'd1);
    chk("collide_ready", {31'd0, a_ready}, 32'd0);
    n = 0;
    while (a_busy && n < 100) begin
      if (n == 3) a_clr = 1'b1;   // second clear_start mid-sweep
      @(posedge clk); #1; n++;
      a_clr = 1'b0;
    end
    chk("collide_busy_edges", n, 32'd16);
    issue(0, 0, 4'd2, '0, '0, 0, 32'hDEADBEEF, 0);
    idle();
    @(posedge clk); #1;

    // Reset mid-clear: drop rst_n at cycle 5 of the sweep for 2 cycles
    p0 = a_pulses;
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    chk("mid_busy_start", {31'd0, a_busy}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, a_busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rel_busy", {31'd0, a_busy}, 32'd1);
    wait_ready(na, nb);
    chk("mid_clear_edges", na, 32'd16);
    chk("mid_no_rsp", a_pulses - p0, 32'd0);
    chk("mid_rdata_reset", a_rdata, 32'd0);

    // Instance B: out-of-range write dropped, read flagged
    issue(1, 1, 4'd13, 32'hBEEF, 4'h3, 0, '0, 0);
    issue(1, 0, 4'd13, '0, '0, 0, 32'h0, 1);
    for (int i = 0; i < 12; i++) begin
      issue(1, 0, 4'(i), '0, '0, 0, 32'h0000C1EA, 0);
    end
    issue(1, 0, 4'd12, '0, '0, 0, 32'h0, 1);
    idle();
    repeat (3) @(posedge clk);
    #1;

    chk("A_queue_drained", qa.size(), 32'd0);
    chk("B_queue_drained", qb.size(), 32'd0);
    chk("B_pulse_count", b_pulses, 32'd14);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
